// File: rtl/shift_abus_pkg.sv
// rtl/shift_abus_pkg.sv - shared types and decode constants for the A-bus shifter
package shift_abus_pkg;

    typedef enum logic [1:0] {
        LSR  = 2'b00,
        ASR  = 2'b01,
        LSL  = 2'b10,
        PASS = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // cpipe bits 7,5,4,3,2,0 must read 1,1,0,0,0,0 to enable the shifter
    localparam logic [7:0] EN_MASK  = 8'b1011_1101;
    localparam logic [7:0] EN_VALUE = 8'b1010_0000;

    function automatic logic cpipe_en(input logic [7:0] cpipe);
        return (cpipe & EN_MASK) == EN_VALUE;
    endfunction

    function automatic mode_e cpipe_mode(input logic [7:0] cpipe);
        return mode_e'({cpipe[6], cpipe[1]});
    endfunction

endpackage

// File: rtl/shift_abus_step.sv
// rtl/shift_abus_step.sv - combinational single-bit shift of the working register
module shift_abus_step
    import shift_abus_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  mode_e        mode,
    output logic [W-1:0] result
);

    always_comb begin
        result = data;
        unique case (mode)
            LSR:  result = {1'b0, data[W-1:1]};
            ASR:  result = {data[W-1], data[W-1:1]};
            LSL:  result = {data[W-2:0], 1'b0};
            PASS: result = data;
        endcase
    end

endmodule

// File: rtl/shift_abus_seq.sv
// rtl/shift_abus_seq.sv - sequential one-bit-per-cycle A-bus shifter with valid/ready handshakes
module shift_abus_seq
    import shift_abus_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cpipe,
    input  logic [W-1:0]  ai_data,
    input  logic [AW-1:0] amt,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  shift_abus,
    output logic          out_valid,
    input  logic          out_ready
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [W-1:0]  work_q, work_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  step_out;
    logic          en;
    mode_e         in_mode;

    assign en      = cpipe_en(cpipe);
    assign in_mode = cpipe_mode(cpipe);

    shift_abus_step #(.W(W)) u_step (
        .data   (work_q),
        .mode   (mode_q),
        .result (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= LSR;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    work_d  = en ? ai_data : '0;
                    cnt_d   = amt;
                    state_d = (en && in_mode != PASS && amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // the shift on the cycle the counter reads 1 is the final one
                work_d = step_out;
                cnt_d  = cnt_q - AW'(1);
                if (cnt_q == AW'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rst_n gates in_ready so nothing looks acceptable while reset is held
    assign in_ready   = rst_n && (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign shift_abus = out_valid ? work_q : '0;

endmodule

// File: tb/tb_shift_abus_seq.sv
// tb/tb_shift_abus_seq.sv - directed self-checking bench for shift_abus_seq
module tb_shift_abus_seq;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cpipe;
    logic [31:0] ai_data;
    logic [4:0]  amt;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] shift_abus;
    logic        out_valid;
    logic        out_ready;

    int tests;
    int fails;

    shift_abus_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpipe      (cpipe),
        .ai_data    (ai_data),
        .amt        (amt),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_abus (shift_abus),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accepts one request, scrambles the inputs, and waits (bounded) for out_valid.
    task automatic run_req(input string tag, input logic [7:0] cp, input logic [31:0] d,
                           input logic [4:0] a, input int exp_lat, input logic [31:0] exp_val);
        int edges;
        cpipe    = cp;
        ai_data  = d;
        amt      = a;
        in_valid = 1'b1;
        tick();
        edges    = 1;
        in_valid = 1'b0;
        cpipe    = 8'h5F;
        ai_data  = 32'hDEAD_BEEF;
        amt      = 5'd17;
        while (!out_valid && edges < 64) begin
            tick();
            edges++;
        end
        chk({tag, "_lat"}, 32'(edges), 32'(exp_lat));
        chk({tag, "_val"}, shift_abus, exp_val);
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        bit seen_valid;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        cpipe     = 8'h00;
        ai_data   = '0;
        amt       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_bus", shift_abus, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_req("lsr1",     8'hA0, 32'h8000_0001, 5'd1,  2,  32'h4000_0000);
        run_req("asr31",    8'hA2, 32'h8000_0000, 5'd31, 32, 32'hFFFF_FFFF);
        run_req("lsl4",     8'hE0, 32'h0000_0003, 5'd4,  5,  32'h0000_0030);
        run_req("pass7",    8'hE2, 32'h1234_5678, 5'd7,  1,  32'h1234_5678);
        run_req("disabled", 8'hA1, 32'hFFFF_FFFF, 5'd5,  1,  32'h0000_0000);
        run_req("lsr31",    8'hA0, 32'h8000_0000, 5'd31, 32, 32'h0000_0001);
        run_req("amt0",     8'hA0, 32'h0000_0005, 5'd0,  1,  32'h0000_0005);
        run_req("asr_pos",  8'hA2, 32'h4000_0000, 5'd2,  3,  32'h1000_0000);

        // Backpressure: result must hold while out_ready stays low.
        cpipe    = 8'hA0;
        ai_data  = 32'h0000_00F0;
        amt      = 5'd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_val", shift_abus, 32'h0000_000F);
            chk("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset on the third SHIFT edge of an amt=10 request.
        cpipe    = 8'hA0;
        ai_data  = 32'hFFFF_FFFF;
        amt      = 5'd10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_bus", shift_abus, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("midrst_no_result", {31'd0, seen_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_abus_seq.md
SHIFT_ABUS_SEQ -- requirements
Module: shift_abus_seq

Interface
REQ-001 Parameter W, default 32, data width of the A-bus (W >= 4, power of two).
REQ-002 Parameter AW, default $clog2(W), width of the shift-amount field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cpipe  input  8  pipeline control word; bits 7,5,4,3,2,0 form the enable decode, bits 6,1 form the mode.
REQ-006 ai_data  input  W  processed A operand.
REQ-007 amt  input  AW  shift count, 0..W-1.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 shift_abus  output  W  result bus.
REQ-011 out_valid  output  1  shift_abus holds a result.
REQ-012 out_ready  input  1  consumer accepts result.

Function
REQ-013 Request accepted on any edge with in_valid & in_ready; cpipe, ai_data, amt captured at acceptance.
REQ-014 Enable decode: en = cpipe[7] & cpipe[5] & ~cpipe[4] & ~cpipe[3] & ~cpipe[2] & ~cpipe[0].
REQ-015 Mode {cpipe[6],cpipe[1]}: 00 logical right (MSB fill 0), 01 arithmetic right (MSB fill ai_data[W-1]), 10 logical left (LSB fill 0), 11 pass-through.
REQ-016 en=0 at acceptance: result is all zeros regardless of mode/amt.
REQ-017 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-018 IDLE: in_ready=1; on accept, load working reg with ai_data (or 0 if en=0), load counter with amt; go SHIFT if en & mode!=11 & amt!=0, else DONE.
REQ-019 SHIFT: one single-bit shift per cycle per mode; counter decrements; on cycle where counter reaches 1 perform last shift and go DONE.
REQ-020 Latency accept-to-out_valid: 1 cycle for pass/disabled/amt=0, amt+1 cycles otherwise.
REQ-021 DONE: out_valid=1, shift_abus = working reg, held stable until out_ready; on out_valid & out_ready go IDLE.
REQ-022 in_ready=0 in SHIFT and DONE; no accept-and-complete in the same cycle (one request in flight).
REQ-023 shift_abus = 0 whenever out_valid=0.
REQ-024 amt=W-1, mode 00: result bit0 = original MSB, all others 0; mode 01: all bits = original MSB.
REQ-025 Changes on cpipe/ai_data/amt after acceptance have no effect on the in-flight result.

Reset
REQ-026 rst_n=0 at an edge forces IDLE, out_valid=0, shift_abus=0, counter=0, working reg=0, including mid-SHIFT or in DONE; in-flight request is discarded.
REQ-027 in_ready=1 on the first edge after rst_n returns high; in_ready=0 while rst_n=0.

Structure
REQ-028 Shared package shift_abus_pkg holds the mode enum (LSR, ASR, LSL, PASS), the state enum, and the enable-decode mask/value constants (mask 8'b1011_1101, value 8'b1010_0000).
REQ-029 One sub-module shift_abus_step: combinational single-bit shift of W bits by mode; FSM and counter stay in the top.

Verification
REQ-030 W=32, cpipe=8'hA0 (mode LSR), ai_data=32'h8000_0001, amt=1 -> out_valid after 2 cycles, shift_abus=32'h4000_0000.
REQ-031 cpipe=8'hA2 (ASR), ai_data=32'h8000_0000, amt=31 -> after 32 cycles shift_abus=32'hFFFF_FFFF.
REQ-032 cpipe=8'hE0 (LSL), ai_data=32'h0000_0003, amt=4 -> shift_abus=32'h0000_0030; cpipe=8'hE2 (PASS), amt=7 -> ai_data unchanged after 1 cycle.
REQ-033 cpipe=8'hA1 (bit0 set, en=0), ai_data=32'hFFFF_FFFF -> 1 cycle later out_valid=1, shift_abus=0.
REQ-034 out_ready held 0 for 5 cycles in DONE -> shift_abus and out_valid stable, in_ready=0; out_ready=1 -> next cycle IDLE, in_ready=1.
REQ-035 rst_n=0 for one edge at SHIFT cycle 3 of amt=10 request -> IDLE, out_valid=0, shift_abus=0, no result delivered.
